// File: rtl/circle_frame_writer.sv
// circle_frame_writer: scans a frame column-major into a BRAM write port, pixel chosen by mode (solid/circle/checker).
// Ports: clk, rst_n (async active-low); start/abort control; mode, cx, cy, radius, fg_color, bg_color
// are latched on start; BRAM_PORTA_addr/din/we form the write port; busy spans the frame, done pulses at its end.
module circle_frame_writer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [15:0]       cx,
    input  logic [15:0]       cy,
    input  logic [15:0]       radius,
    input  logic [PIX_W-1:0]  fg_color,
    input  logic [PIX_W-1:0]  bg_color,
    output logic [ADDR_W-1:0] BRAM_PORTA_addr,
    output logic [PIX_W-1:0]  BRAM_PORTA_din,
    output logic              BRAM_PORTA_we,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [15:0]       X_LAST = 16'(H_RES - 1);
    localparam logic [15:0]       Y_LAST = 16'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [1:0]        mode_r;
    logic [15:0]       cx_r, cy_r, rad_r, x, y;
    logic [PIX_W-1:0]  fg_r, bg_r;
    logic              s1_v, s1_chk, s2_v, s2_fg;
    logic signed [16:0] dx, dy;
    logic signed [34:0] dxe, dye, d2;
    logic [31:0]       rr;
    logic              accept, issue, last_xy, fin, in_circ, wr;

    assign accept  = state == IDLE && start && !abort;
    assign issue   = state == RUN;
    assign last_xy = x == X_LAST && y == Y_LAST;
    // Last write is on the port this cycle, so the pipeline is empty after the edge.
    assign fin     = state == DRAIN && BRAM_PORTA_we && BRAM_PORTA_addr == LAST;
    assign busy    = state != IDLE;
    // Sign-extend before squaring so the sum of squares never overflows.
    assign dxe     = 35'(dx);
    assign dye     = 35'(dy);
    assign d2      = dxe * dxe + dye * dye;
    assign rr      = 32'(rad_r) * 32'(rad_r);
    assign in_circ = $unsigned(d2) <= {3'b000, rr};
    assign wr      = s2_v && !abort;

    always_comb begin
        state_nx = state;
        if (abort && state != IDLE)
            state_nx = IDLE;
        else if (accept)
            state_nx = RUN;
        else if (issue && last_xy)
            state_nx = DRAIN;
        else if (fin)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_r          <= '0;
            cx_r            <= '0;
            cy_r            <= '0;
            rad_r           <= '0;
            fg_r            <= '0;
            bg_r            <= '0;
            x               <= '0;
            y               <= '0;
            s1_v            <= 1'b0;
            s1_chk          <= 1'b0;
            dx              <= '0;
            dy              <= '0;
            s2_v            <= 1'b0;
            s2_fg           <= 1'b0;
            BRAM_PORTA_we   <= 1'b0;
            BRAM_PORTA_addr <= '0;
            BRAM_PORTA_din  <= '0;
            done            <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mode_r <= mode;
                cx_r   <= cx;
                cy_r   <= cy;
                rad_r  <= radius;
                fg_r   <= fg_color;
                bg_r   <= bg_color;
                x      <= '0;
                y      <= '0;
            end else if (issue) begin
                y <= (y == Y_LAST) ? 16'd0 : y + 16'd1;
                x <= (y == Y_LAST) ? x + 16'd1 : x;
            end
            s1_v            <= issue && !abort;
            dx              <= $signed({1'b0, x}) - $signed({1'b0, cx_r});
            dy              <= $signed({1'b0, y}) - $signed({1'b0, cy_r});
            s1_chk          <= ~(x[3] ^ y[3]);
            s2_v            <= s1_v && !abort;
            s2_fg           <= mode_r == 2'd0 ? 1'b1 : mode_r == 2'd1 ? in_circ : mode_r == 2'd2 ? s1_chk : 1'b0;
            BRAM_PORTA_we   <= wr;
            // Writes of a frame are contiguous, so the address just counts from 0.
            BRAM_PORTA_addr <= wr ? (BRAM_PORTA_we ? BRAM_PORTA_addr + ADDR_W'(1) : '0) : '0;
            BRAM_PORTA_din  <= wr ? (s2_fg ? fg_r : bg_r) : '0;
            done            <= fin && !abort;
        end
    end
endmodule

// File: tb/tb_circle_frame_writer.sv
// tb_circle_frame_writer: directed scoreboard bench for circle_frame_writer on a 16x12 frame.
module tb_circle_frame_writer;
    localparam int H = 16;
    localparam int V = 12;
    localparam int A = 8;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] cx = '0, cy = '0, radius = '0;
    logic [11:0] fg_color = '0, bg_color = '0;
    logic [A-1:0] addr;
    logic [11:0] din;
    logic        we, busy, done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [19:0] q[$];
    logic [19:0] e_mon;
    logic        prev_we = 1'b0;
    logic [A-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    circle_frame_writer #(.H_RES(H), .V_RES(V), .PIX_W(12), .ADDR_W(A)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .cx(cx), .cy(cy), .radius(radius), .fg_color(fg_color), .bg_color(bg_color),
        .BRAM_PORTA_addr(addr), .BRAM_PORTA_din(din), .BRAM_PORTA_we(we),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input int x, input int y, input logic [1:0] m,
                                          input logic [15:0] x0, input logic [15:0] y0,
                                          input logic [15:0] r, input logic [11:0] f, input logic [11:0] b);
        longint ddx, ddy, rsq;
        ddx = longint'(x) - longint'(x0);
        ddy = longint'(y) - longint'(y0);
        rsq = longint'(r) * longint'(r);
        case (m)
            2'd0:    return f;
            2'd1:    return (ddx * ddx + ddy * ddy <= rsq) ? f : b;
            2'd2:    return ((((x >> 3) ^ (y >> 3)) & 1) == 0) ? f : b;
            default: return b;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m, input logic [15:0] x0, input logic [15:0] y0,
                              input logic [15:0] r, input logic [11:0] f, input logic [11:0] b);
        for (int x = 0; x < H; x++)
            for (int y = 0; y < V; y++)
                q.push_back({8'(x * V + y), model(x, y, m, x0, y0, r, f, b)});
    endtask

    task automatic set_in(input logic [1:0] m, input logic [15:0] x0, input logic [15:0] y0,
                          input logic [15:0] r, input logic [11:0] f, input logic [11:0] b);
        mode = m; cx = x0; cy = y0; radius = r; fg_color = f; bg_color = b;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < N + 20 && done_cnt < target; i++) @(negedge clk);
        @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'(target));
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [15:0] x0, input logic [15:0] y0,
                             input logic [15:0] r, input logic [11:0] f, input logic [11:0] b);
        int d0;
        d0 = done_cnt;
        set_in(m, x0, y0, r, f, b);
        push_frame(m, x0, y0, r, f, b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_in(~m, 16'($urandom), 16'($urandom), 16'($urandom), ~f, ~b);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("we_lat1", 64'(we), 64'd0);
        @(negedge clk);
        chk("we_lat2", 64'(we), 64'd0);
        @(negedge clk);
        chk("we_lat3", 64'(we), 64'd0);
        @(negedge clk);
        chk("first_we", 64'(we), 64'd1);
        chk("first_addr", 64'(addr), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
            prev_addr = '0;
        end else begin
            if (we) begin
                if (q.size() == 0) chk("extra_write", 64'(we), 64'd0);
                else begin
                    e_mon = q.pop_front();
                    chk("addr", 64'(addr), 64'(e_mon[19:12]));
                    chk("din", 64'(din), 64'(e_mon[11:0]));
                end
            end else begin
                chk("idle_addr", 64'(addr), 64'd0);
                chk("idle_din", 64'(din), 64'd0);
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", 64'({prev_we, prev_addr}), 64'({1'b1, 8'(N - 1)}));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            prev_we = we;
            prev_addr = addr;
        end
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_din", 64'(din), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(2'd0, 16'd0, 16'd0, 16'd0, 12'h5A5, 12'h111);
        run_frame(2'd1, 16'd7, 16'd5, 16'd4, 12'h000, 12'hFFF);
        run_frame(2'd2, 16'd0, 16'd0, 16'd0, 12'hABC, 12'h123);
        run_frame(2'd3, 16'd0, 16'd0, 16'd0, 12'h777, 12'h246);
        run_frame(2'd1, 16'd500, 16'd500, 16'd0, 12'hF00, 12'h0F0);
        run_frame(2'd1, 16'd3, 16'd3, 16'd0, 12'hF00, 12'h0F0);
        run_frame(2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 12'h00F, 12'hF0F);
        run_frame(2'd1, 16'hFFFF, 16'd0, 16'hFFFF, 12'h00F, 12'hF0F);
        run_frame(2'd1, 16'd0, 16'd0, 16'd10, 12'h000, 12'hFFF);

        // abort on the 10th write
        d0 = done_cnt;
        set_in(2'd2, 16'd0, 16'd0, 16'd0, 12'hABC, 12'h123);
        push_frame(2'd2, 16'd0, 16'd0, 16'd0, 12'hABC, 12'h123);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !(we && addr == 8'd9); i++) @(negedge clk);
        chk("abort_at_10th", 64'({we, addr}), 64'({1'b1, 8'd9}));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_we", 64'(we), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        q.delete();
        repeat (8) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        run_frame(2'd2, 16'd0, 16'd0, 16'd0, 12'h321, 12'h654);

        // abort together with start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("idle_abort_we", 64'(we), 64'd0);

        // reset mid-frame
        d0 = done_cnt;
        set_in(2'd0, 16'd0, 16'd0, 16'd0, 12'h999, 12'h000);
        push_frame(2'd0, 16'd0, 16'd0, 16'd0, 12'h999, 12'h000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(we), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        chk("arst_din", 64'(din), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        chk("arst_wait_busy", 64'(busy), 64'd0);
        chk("arst_no_done", 64'(done_cnt), 64'(d0));
        run_frame(2'd1, 16'd8, 16'd6, 16'd5, 12'hC0C, 12'h3F3);

        // start held high across a frame; inputs change mid-frame
        d0 = done_cnt;
        set_in(2'd1, 16'd8, 16'd6, 16'd5, 12'h0AA, 12'h055);
        push_frame(2'd1, 16'd8, 16'd6, 16'd5, 12'h0AA, 12'h055);
        start = 1'b1;
        @(negedge clk);
        set_in(2'd3, 16'd2, 16'd2, 16'd30, 12'h111, 12'hEEE);
        for (int i = 0; i < N + 20 && !done; i++) @(negedge clk);
        chk("held_done_a", 64'(done), 64'd1);
        push_frame(2'd3, 16'd2, 16'd2, 16'd30, 12'h111, 12'hEEE);
        @(negedge clk);
        chk("held_restart_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(d0 + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/circle_frame_writer.md
CIRCLE_FRAME_WRITER -- requirements
Module: circle_frame_writer

Interface
REQ-001 Parameter H_RES, default 320, frame width in pixels (x range 0..H_RES-1).
REQ-002 Parameter V_RES, default 240, frame height in pixels (y range 0..V_RES-1).
REQ-003 Parameter PIX_W, default 12, pixel width in bits.
REQ-004 Parameter ADDR_W, default 17, BRAM address width; SHALL satisfy 2^ADDR_W >= H_RES*V_RES.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to draw a frame; sampled only in IDLE.
REQ-008 abort  in  1  terminate an in-progress frame.
REQ-009 mode  in  2  0 = solid fg, 1 = circle, 2 = checkerboard 8x8, 3 = solid bg.
REQ-010 cx, cy  in  16 each  circle centre in pixels, unsigned; values outside the frame are legal.
REQ-011 radius  in  16  circle radius in pixels, unsigned.
REQ-012 fg_color, bg_color  in  PIX_W each  foreground and background pixel values.
REQ-013 BRAM_PORTA_addr  out  ADDR_W  write address.
REQ-014 BRAM_PORTA_din  out  PIX_W  write data.
REQ-015 BRAM_PORTA_we  out  1  write strobe, one pixel per asserted cycle.
REQ-016 busy  out  1  high from the cycle after start is accepted until the last write or an abort.
REQ-017 done  out  1  one-cycle pulse on completion of a full frame.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start; RUN->DRAIN after the last coordinate is issued; DRAIN->IDLE once the pipeline is empty.
REQ-019 On accepting start, latch mode, cx, cy, radius, fg_color and bg_color; input changes during a frame SHALL have no effect.
REQ-020 Scan order: x outer 0..H_RES-1, y inner 0..V_RES-1; addr = x*V_RES + y, incremented by 1 per write, no gaps.
REQ-021 Coordinate generator issues one (x,y) per cycle in RUN; the pipeline is 2 stages (stage 1: dx = x-cx, dy = y-cy, signed, 17 bits; stage 2: dx*dx + dy*dy, 35 bits, compared against radius*radius, 32 bits).
REQ-022 All arithmetic SHALL be full-width with no truncation or overflow for any input value.
REQ-023 Circle mode: pixel = fg_color when dx*dx+dy*dy <= radius*radius, else bg_color; radius 0 yields fg at (cx,cy) only.
REQ-024 Checker mode: pixel = fg_color when x[3] XOR y[3] = 0, else bg_color.
REQ-025 Latency: start sampled at edge N -> the first write (addr 0, we=1) SHALL be presented on the outputs after edge N+3; writes continue back-to-back for H_RES*V_RES cycles.
REQ-026 The last write uses addr H_RES*V_RES-1; the address SHALL NOT wrap or exceed this value.
REQ-027 done SHALL pulse in the cycle after the last write; busy SHALL fall in the same cycle.
REQ-028 start while busy SHALL be ignored; start in the same cycle as the done pulse SHALL be accepted.
REQ-029 abort during RUN or DRAIN: after the next edge, we=0, busy=0, FSM=IDLE, and no done pulse; abort in IDLE has no effect; abort wins over start in the same cycle.
REQ-030 When we=0, addr and din SHALL hold 0.

Reset
REQ-031 While rst_n=0: FSM=IDLE, BRAM_PORTA_addr=0, BRAM_PORTA_din=0, BRAM_PORTA_we=0, busy=0, done=0, and the pipeline is flushed.
REQ-032 Reset asserted mid-frame SHALL drop we immediately (asynchronously); no done pulse follows, and after release the block waits for a fresh start.

Verification
REQ-033 Default parameters, mode=1, cx=0, cy=0, radius=100, fg=0x000, bg=0xFFF -> 76800 writes with addr 0..76799; pixel 0x000 exactly where x^2+y^2 <= 10000; done pulses once.
REQ-034 H_RES=8, V_RES=4, mode=2, fg=0xABC, bg=0x123 -> 32 consecutive writes, all 0xABC (x,y < 8); first we 3 cycles after start; done in the cycle after addr 31.
REQ-035 H_RES=16, V_RES=16, mode=1, cx=500, cy=500, radius=0 -> 256 writes, all bg_color.
REQ-036 Abort asserted on the 10th write of a 32-pixel frame -> we=0 after the next edge, busy=0, no done pulse; a following start redraws from addr 0.
REQ-037 rst_n pulsed low mid-frame -> we=0 and busy=0 asynchronously; a start 2 cycles after release produces a full frame.
REQ-038 start held high for the whole frame and changed to mode=3 mid-frame -> one frame only, drawn in the latched mode; a second frame starts in the cycle after done.
